// File: rtl/muldiv_iterative_if.sv
// Start/busy/done handshake bundle between the core and the iterative RV32M unit.
interface muldiv_iterative_if;
    logic        iStart;
    logic [2:0]  iFunct3;
    logic [31:0] iRs1Data;
    logic [31:0] iRs2Data;
    logic [4:0]  iRd;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oResult;
    logic [4:0]  oRd;

    modport master (
        output iStart, iFunct3, iRs1Data, iRs2Data, iRd,
        input  oBusy, oDone, oResult, oRd
    );

    modport slave (
        input  iStart, iFunct3, iRs1Data, iRs2Data, iRd,
        output oBusy, oDone, oResult, oRd
    );
endinterface

// File: rtl/muldiv_iterative.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide.
// Define FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_iterative (
    input logic               iCLK,
    input logic               iRST,
    muldiv_iterative_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} stateT;

    stateT       stateQ, stateD;
    logic [5:0]  cntQ, cntD;
    logic [1:0]  opSelQ, opSelD;
    logic [63:0] accQ, accD;
    logic [32:0] remQ, remD;
    logic [31:0] opBQ, opBD;
    logic        negQuotQ, negQuotD, negRemQ, negRemD;
    logic        shortQ, shortD;
    logic [4:0]  rdPendQ, rdPendD, rdQ, rdD;
    logic [31:0] resultQ, resultD;

    logic        aSigned, bSigned, negA, negB;
    logic [31:0] magA, magB;
    logic        divByZero, divOverflow;
    logic [32:0] mulSum;
    logic [63:0] mulNext, prodFix;
    logic [33:0] divShift, divDiff;
    logic [32:0] divRemNext;
    logic [31:0] divQuotNext, quotFix, remFix;

    // MUL is treated as unsigned: the low product word does not depend on signedness.
    assign aSigned     = (bus.iFunct3 == 3'b001) || (bus.iFunct3 == 3'b010) ||
                         (bus.iFunct3 == 3'b100) || (bus.iFunct3 == 3'b110);
    assign bSigned     = (bus.iFunct3 == 3'b001) || (bus.iFunct3 == 3'b100) ||
                         (bus.iFunct3 == 3'b110);
    assign negA        = aSigned && bus.iRs1Data[31];
    assign negB        = bSigned && bus.iRs2Data[31];
    assign magA        = negA ? -bus.iRs1Data : bus.iRs1Data;
    assign magB        = negB ? -bus.iRs2Data : bus.iRs2Data;
    assign divByZero   = (bus.iRs2Data == 32'd0);
    assign divOverflow = !bus.iFunct3[0] && (bus.iRs1Data == 32'h8000_0000) &&
                         (bus.iRs2Data == 32'hFFFF_FFFF);

    // Multiplier sits in accQ[31:0] and shifts out as the product shifts in.
    assign mulSum  = {1'b0, accQ[63:32]} + (accQ[0] ? {1'b0, opBQ} : 33'd0);
    assign mulNext = {mulSum, accQ[31:1]};
    assign prodFix = negQuotQ ? -mulNext : mulNext;

    // Dividend sits in accQ[31:0] and is replaced by quotient bits from the bottom.
    assign divShift    = {remQ, accQ[31]};
    assign divDiff     = divShift - {2'b00, opBQ};
    assign divRemNext  = divDiff[33] ? divShift[32:0] : divDiff[32:0];
    assign divQuotNext = {accQ[30:0], ~divDiff[33]};
    assign quotFix     = negQuotQ ? -divQuotNext : divQuotNext;
    assign remFix      = negRemQ ? -divRemNext[31:0] : divRemNext[31:0];

`ifdef FAST_MUL_EN
    logic [63:0] fastProd, fastFix;
    assign fastProd = {32'd0, magA} * {32'd0, magB};
    assign fastFix  = (negA ^ negB) ? -fastProd : fastProd;
`endif

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        opSelD   = opSelQ;
        accD     = accQ;
        remD     = remQ;
        opBD     = opBQ;
        negQuotD = negQuotQ;
        negRemD  = negRemQ;
        shortD   = shortQ;
        rdPendD  = rdPendQ;
        rdD      = rdQ;
        resultD  = resultQ;
        unique case (stateQ)
            StIdle, StDone: begin
                // Short ops spend one settle cycle here so done lands one edge after accept.
                if (shortQ) begin
                    stateD = StDone;
                    shortD = 1'b0;
                end else if (bus.iStart) begin
                    opSelD   = bus.iFunct3[1:0];
                    cntD     = 6'd0;
                    rdPendD  = bus.iRd;
                    negQuotD = negA ^ negB;
                    negRemD  = negA;
                    if (bus.iFunct3[2]) begin
                        if (divByZero) begin
                            resultD = bus.iFunct3[1] ? bus.iRs1Data : 32'hFFFF_FFFF;
                            rdD     = bus.iRd;
                            stateD  = StIdle;
                            shortD  = 1'b1;
                        end else if (divOverflow) begin
                            resultD = bus.iFunct3[1] ? 32'd0 : 32'h8000_0000;
                            rdD     = bus.iRd;
                            stateD  = StIdle;
                            shortD  = 1'b1;
                        end else begin
                            accD   = {32'd0, magA};
                            remD   = 33'd0;
                            opBD   = magB;
                            stateD = StDiv;
                        end
                    end else begin
`ifdef FAST_MUL_EN
                        resultD = (bus.iFunct3[1:0] == 2'b00) ? fastFix[31:0] : fastFix[63:32];
                        rdD     = bus.iRd;
                        stateD  = StIdle;
                        shortD  = 1'b1;
`else
                        accD   = {32'd0, magB};
                        opBD   = magA;
                        stateD = StMul;
`endif
                    end
                end else if (stateQ == StDone) begin
                    stateD = StIdle;
                end
            end
            StMul: begin
                accD = mulNext;
                cntD = cntQ + 6'd1;
                if (cntQ == 6'd31) begin
                    resultD = (opSelQ == 2'b00) ? prodFix[31:0] : prodFix[63:32];
                    rdD     = rdPendQ;
                    stateD  = StDone;
                end
            end
            StDiv: begin
                accD = {32'd0, divQuotNext};
                remD = divRemNext;
                cntD = cntQ + 6'd1;
                if (cntQ == 6'd31) begin
                    resultD = opSelQ[1] ? remFix : quotFix;
                    rdD     = rdPendQ;
                    stateD  = StDone;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateQ   <= StIdle;
            cntQ     <= 6'd0;
            opSelQ   <= 2'd0;
            accQ     <= 64'd0;
            remQ     <= 33'd0;
            opBQ     <= 32'd0;
            negQuotQ <= 1'b0;
            negRemQ  <= 1'b0;
            shortQ   <= 1'b0;
            rdPendQ  <= 5'd0;
            rdQ      <= 5'd0;
            resultQ  <= 32'd0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            opSelQ   <= opSelD;
            accQ     <= accD;
            remQ     <= remD;
            opBQ     <= opBD;
            negQuotQ <= negQuotD;
            negRemQ  <= negRemD;
            shortQ   <= shortD;
            rdPendQ  <= rdPendD;
            rdQ      <= rdD;
            resultQ  <= resultD;
        end
    end

    assign bus.oBusy   = (stateQ == StMul) || (stateQ == StDiv);
    assign bus.oDone   = (stateQ == StDone);
    assign bus.oResult = resultQ;
    assign bus.oRd     = rdQ;
endmodule

// File: tb/tb_muldiv_iterative.sv
// Randomized bench for muldiv_iterative against a plain-arithmetic RV32M model.
module tb_muldiv_iterative;
    logic iCLK = 1'b0;
    logic iRST;
    int   nChecks = 0;
    int   nErrors = 0;

    always #5 iCLK = ~iCLK;

    muldiv_iterative_if bus ();

    muldiv_iterative dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit isShort(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) begin
`ifdef FAST_MUL_EN
            return 1'b1;
`else
            return 1'b0;
`endif
        end
        if (b == 0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Sample k=0 is the one just after the accepting edge.
    task automatic waitDone(output int doneAt, output int busyCnt);
        doneAt  = -1;
        busyCnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge iCLK);
                #1;
            end
            if (bus.oDone) begin
                doneAt = k;
                break;
            end
            if (bus.oBusy) busyCnt++;
        end
    endtask

    task automatic scramble();
        bus.iFunct3  = 3'($urandom);
        bus.iRs1Data = $urandom;
        bus.iRs2Data = $urandom;
        bus.iRd      = 5'($urandom);
    endtask

    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int  doneAt, busyCnt;
        bit  sh;
        sh = isShort(f3, a, b);
        @(negedge iCLK);
        bus.iFunct3  = f3;
        bus.iRs1Data = a;
        bus.iRs2Data = b;
        bus.iRd      = rd;
        bus.iStart   = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iStart = 1'b0;
        scramble();
        waitDone(doneAt, busyCnt);
        check({tag, " latency"}, doneAt, sh ? 1 : 32);
        check({tag, " busy cycles"}, busyCnt, sh ? 0 : 32);
        check({tag, " result"}, bus.oResult, refModel(f3, a, b));
        check({tag, " rd"}, bus.oRd, rd);
        @(posedge iCLK);
        #1;
        check({tag, " done pulse"}, bus.oDone, 1'b0);
    endtask

    initial begin
        int doneAt, busyCnt;
        iRST         = 1'b1;
        bus.iStart   = 1'b0;
        bus.iFunct3  = 3'd0;
        bus.iRs1Data = 32'd0;
        bus.iRs2Data = 32'd0;
        bus.iRd      = 5'd0;
        #12;
        check("reset outputs", {bus.oBusy, bus.oDone, bus.oResult, bus.oRd}, 39'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        runOp("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        runOp("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
        runOp("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        runOp("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        runOp("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
        runOp("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        runOp("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd7);
        runOp("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd8);
        runOp("div by 0", 3'd4, 32'd5, 32'd0, 5'd9);
        runOp("remu by 0", 3'd7, 32'd5, 32'd0, 5'd10);
        runOp("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        runOp("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // Back-to-back: iStart stays high from the first accept through DONE.
        @(negedge iCLK);
        bus.iFunct3  = 3'd5;
        bus.iRs1Data = 32'd100;
        bus.iRs2Data = 32'd7;
        bus.iRd      = 5'd13;
        bus.iStart   = 1'b1;
        @(posedge iCLK);
        #1;
        scramble();
        waitDone(doneAt, busyCnt);
        check("b2b first latency", doneAt, 32);
        check("b2b first result", bus.oResult, 32'd14);
        check("b2b first rd", bus.oRd, 5'd13);
        bus.iFunct3  = 3'd0;
        bus.iRs1Data = 32'd7;
        bus.iRs2Data = 32'hFFFF_FFFD;
        bus.iRd      = 5'd14;
        @(posedge iCLK);
        #1;
        bus.iStart = 1'b0;
        scramble();
        check("b2b accept in done", {bus.oBusy, bus.oDone},
              isShort(3'd0, 32'd7, 32'hFFFF_FFFD) ? 2'b00 : 2'b10);
        waitDone(doneAt, busyCnt);
        check("b2b second latency", doneAt, isShort(3'd0, 32'd7, 32'hFFFF_FFFD) ? 1 : 32);
        check("b2b second result", bus.oResult, 32'hFFFF_FFEB);
        check("b2b second rd", bus.oRd, 5'd14);

        // Asynchronous reset partway through a divide.
        @(negedge iCLK);
        bus.iFunct3  = 3'd4;
        bus.iRs1Data = 32'hFFFF_FFF9;
        bus.iRs2Data = 32'd2;
        bus.iRd      = 5'd15;
        bus.iStart   = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iStart = 1'b0;
        repeat (10) @(posedge iCLK);
        #1;
        check("busy before reset", bus.oBusy, 1'b1);
        iRST = 1'b1;
        #1;
        check("async reset outputs", {bus.oBusy, bus.oDone, bus.oResult, bus.oRd}, 39'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        runOp("divu 9/3 after reset", 3'd5, 32'd9, 32'd3, 5'd16);

        for (int i = 0; i < 40; i++) begin
            runOp("random", 3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                  5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/muldiv_iterative.md
# muldiv_iterative

Iterative RV32M multiply/divide unit placed between the register-file read ports and the write-back mux. It takes rs1/rs2 operand values and a funct3 code, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over several cycles, and returns a 32-bit result with its destination register index for write-back. Handshake is start/busy/done, so the core control stalls while the unit is busy.

## Interface
- No parameters; fixed 32-bit datapath.
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iStart  in  1  request; sampled only when oBusy=0.
- iFunct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iRs1Data  in  32  operand A (dividend / multiplicand).
- iRs2Data  in  32  operand B (divisor / multiplier).
- iRd  in  5  destination register index, carried through.
- oBusy  out  1  high in MUL and DIV states.
- oDone  out  1  one-cycle pulse; result valid.
- oResult  out  32  result, held until the next accepted start.
- oRd  out  5  captured iRd, held alongside oResult.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE/DONE + iStart=1: latch operands, funct3, iRd, and zero the 6-bit step counter. Go to MUL (funct3[2]=0) or DIV (funct3[2]=1), except for the special divide cases below.
- DONE with no iStart: go to IDLE.
- Signed handling: for signed ops, take the absolute value of each signed operand and record the result sign.
  - MULHSU treats only A as signed.
  - The quotient sign is the XOR of the operand signs; the remainder sign follows the dividend.
  - The final result is two's-complement negated when the sign is set.
- MUL state: shift-add over a 64-bit accumulator, one multiplier bit per cycle, 32 steps. MUL returns product[31:0]; the MULH variants return product[63:32].
- DIV state: restoring division, one quotient bit per cycle, 32 steps, 33-bit partial remainder. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special divide cases resolve at the start cycle and go directly to DONE:
  - Divisor = 0: quotient = 0xFFFFFFFF and remainder = A, for both signed and unsigned ops.
  - Signed overflow, A = 0x80000000 with B = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- After step 32 the unit applies the sign fix-up, loads oResult/oRd, and goes to DONE.
- oDone is high for exactly the cycle spent in DONE.
- Results are never written for rd=x0 by this block; write-back gating for x0 belongs to the register file.

## Timing
- Reset values: state IDLE, oBusy=0, oDone=0, oResult=0, oRd=0, counter=0, internal accumulators 0.
- Normal op, start sampled at edge N:
  - oBusy is high after edges N..N+31 and low after N+32.
  - oDone is high after edge N+32 and low after N+33.
  - Latency is 32 cycles to oDone.
- Special divide cases: oDone is high after edge N+1; oBusy never asserts.
- Back-to-back: iStart high during the DONE cycle is accepted. oDone drops and the new op begins, giving zero dead cycles.
- iStart, operand, and funct3 changes while busy are ignored; operands are captured only at accept.
- Async reset mid-operation aborts immediately to IDLE and clears all outputs. The first start after release is handled normally.

## Configuration
- FAST_MUL_EN defined: multiply ops use a single-cycle combinational 64-bit product. They go IDLE→DONE with oDone high after edge N+1, and the MUL state is never entered. Divide timing is unchanged.
- FAST_MUL_EN undefined: multiplies are iterative, 32 cycles, as above.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3):
  - Iterative build: oResult = 0xFFFFFFEB, oDone after edge N+32, oBusy high for 32 cycles.
  - FAST_MUL_EN build: same value, oDone after edge N+1.
- MULH/MULHSU/MULHU with A = 0x80000000, B = 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 / 2 → 0xFFFFFFFF (−1); DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special divide cases, each with oDone after edge N+1 and oBusy never high:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Back-to-back DIVU then MUL with iStart held high through DONE:
  - Second op accepted in the DONE cycle, with the second iRd reflected on oRd.
  - Operand changes during busy have no effect.
- Assert iRST at step 10 of a DIV:
  - All outputs go to 0 and the state goes to IDLE immediately.
  - A fresh DIVU 9 / 3 after release returns 3.
